sim_time: RTL and testbench

- Simulation time base for the sim library: a free-running timestamp plus a one-shot delay timer.
- Clock generators and multipliers use it to:
  - read "now" in picoseconds or nanoseconds;
  - wait a programmable number of picoseconds.
- Time advances by a fixed PERIOD_PS on every rising edge of clk_i.

---
 rtl/sim_time_pkg.sv | 24 ++
 rtl/sim_time_ns_acc.sv | 37 +++
 rtl/sim_time.sv | 108 ++++++++++
 tb/tb_sim_time.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sim_time_pkg.sv
// Shared types and constants for the sim_time time base.
package sim_time_pkg;

  localparam int TIME_W            = 64;
  localparam int PS_PER_NS         = 1000;
  localparam int DEFAULT_PERIOD_PS = 10000;
  localparam longint unsigned MHZ  = 64'd1_000_000;

  typedef logic [TIME_W-1:0] time_t;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } delay_state_t;

  // Clock period in picoseconds for a frequency given in Hz (0 Hz yields 0).
  function automatic time_t freq2period_ps(input time_t freq);
    time_t ps_per_s;
    ps_per_s = 64'd1_000_000_000_000;
    if (freq == '0) return '0;
    return ps_per_s / freq;
  endfunction

endpackage

// File: rtl/sim_time_ns_acc.sv
// Nanosecond counter that follows the picosecond counter using a remainder
// carry instead of a divider.
module sim_time_ns_acc #(
  parameter int PERIOD_PS = sim_time_pkg::DEFAULT_PERIOD_PS,
  parameter int TIME_W    = sim_time_pkg::TIME_W,
  parameter int PS_PER_NS = sim_time_pkg::PS_PER_NS
) (
  input  logic              clk,
  input  logic              rst,
  output logic [TIME_W-1:0] ns_count
);

  localparam logic [TIME_W-1:0] Q_C     = TIME_W'(PERIOD_PS / PS_PER_NS);
  localparam logic [TIME_W-1:0] Q1_C    = Q_C + TIME_W'(1);
  localparam logic [31:0]       R_C     = 32'(PERIOD_PS % PS_PER_NS);
  localparam logic [31:0]       LIMIT_C = 32'(PS_PER_NS);

  logic [31:0] rem;
  logic [31:0] rem_sum;

  assign rem_sum = rem + R_C;

  // The remainder stays below PS_PER_NS, so one conditional subtract suffices.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      ns_count <= '0;
    end else if (rem_sum >= LIMIT_C) begin
      rem      <= rem_sum - LIMIT_C;
      ns_count <= ns_count + Q1_C;
    end else begin
      rem      <= rem_sum;
      ns_count <= ns_count + Q_C;
    end
  end

endmodule

// File: rtl/sim_time.sv
// Free-running ps/ns timestamp with a one-shot picosecond delay timer.
// Optional lap/period capture is enabled by defining SIM_TIME_LAP_EN.
module sim_time #(
  parameter int PERIOD_PS = sim_time_pkg::DEFAULT_PERIOD_PS,
  parameter int TIME_W    = sim_time_pkg::TIME_W,
  parameter int PS_PER_NS = sim_time_pkg::PS_PER_NS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              unit_ps_i,
  output logic [TIME_W-1:0] now_o,
  input  logic              wait_start_i,
  input  logic [TIME_W-1:0] wait_time_i,
  output logic              busy_o,
  output logic              done_o
`ifdef SIM_TIME_LAP_EN
  ,
  input  logic              capture_i,
  output logic [TIME_W-1:0] lap_o,
  output logic [TIME_W-1:0] delta_o
`endif
);

  import sim_time_pkg::*;

  localparam logic [TIME_W-1:0] PERIOD_C = TIME_W'(PERIOD_PS);

  logic [TIME_W-1:0] ps_count;
  logic [TIME_W-1:0] ns_count;
  logic [TIME_W-1:0] target;
  logic [TIME_W-1:0] target_next;
  logic [TIME_W-1:0] diff;
  logic              expired;
  logic              done;
  logic              done_next;
  delay_state_t      state;
  delay_state_t      state_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) ps_count <= '0;
    else       ps_count <= ps_count + PERIOD_C;
  end

  sim_time_ns_acc #(
    .PERIOD_PS (PERIOD_PS),
    .TIME_W    (TIME_W),
    .PS_PER_NS (PS_PER_NS)
  ) u_ns_acc (
    .clk      (clk_i),
    .rst      (rst_i),
    .ns_count (ns_count)
  );

  assign now_o = unit_ps_i ? ps_count : ns_count;

  // Sign of the wrapping difference keeps the compare valid across counter wrap.
  assign diff    = target - ps_count;
  assign expired = diff[TIME_W-1] | (diff == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      done   <= 1'b0;
      target <= '0;
    end else begin
      state  <= state_next;
      done   <= done_next;
      target <= target_next;
    end
  end

  always_comb begin
    state_next  = state;
    done_next   = 1'b0;
    target_next = target;
    case (state)
      ST_IDLE: begin
        if (wait_start_i) begin
          target_next = ps_count + wait_time_i;
          state_next  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (expired) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_o = (state == ST_BUSY);
  assign done_o = done;

`ifdef SIM_TIME_LAP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lap_o   <= '0;
      delta_o <= '0;
    end else if (capture_i) begin
      lap_o   <= ps_count;
      delta_o <= ps_count - lap_o;
    end
  end
`endif

endmodule

// File: tb/tb_sim_time.sv
// Self-checking bench for sim_time: two instances (10000 ps and 1500 ps periods)
// compared against a cycle-count based reference model.
module tb_sim_time;

  localparam int PER_A = 10000;
  localparam int PER_B = 1500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        unit_ps = 1'b1;
  logic        wait_start = 1'b0;
  logic [63:0] wait_time = '0;
  logic        no_start = 1'b0;
  logic [63:0] no_time = '0;
  logic [63:0] now_a, now_b;
  logic        busy_a, done_a, busy_b, done_b;
`ifdef SIM_TIME_LAP_EN
  logic        capture = 1'b0;
  logic        no_capture = 1'b0;
  logic [63:0] lap_a, delta_a, lap_b, delta_b;
`endif

  int checks = 0;
  int failures = 0;

  longint unsigned cyc = 0;
  longint unsigned m_target = 0;
  longint unsigned m_lap = 0;
  longint unsigned m_delta = 0;
  bit              m_busy = 1'b0;
  bit              m_done = 1'b0;

  always #5 clk = ~clk;

  sim_time #(.PERIOD_PS(PER_A), .TIME_W(64), .PS_PER_NS(1000)) dut_a (
    .clk_i(clk), .rst_i(rst), .unit_ps_i(unit_ps), .now_o(now_a),
    .wait_start_i(wait_start), .wait_time_i(wait_time),
    .busy_o(busy_a), .done_o(done_a)
`ifdef SIM_TIME_LAP_EN
    , .capture_i(capture), .lap_o(lap_a), .delta_o(delta_a)
`endif
  );

  sim_time #(.PERIOD_PS(PER_B), .TIME_W(64), .PS_PER_NS(1000)) dut_b (
    .clk_i(clk), .rst_i(rst), .unit_ps_i(unit_ps), .now_o(now_b),
    .wait_start_i(no_start), .wait_time_i(no_time),
    .busy_o(busy_b), .done_o(done_b)
`ifdef SIM_TIME_LAP_EN
    , .capture_i(no_capture), .lap_o(lap_b), .delta_o(delta_b)
`endif
  );

  // Expected time reading: elapsed cycles times the period, optionally in ns.
  function automatic longint unsigned exp_now(input int period, input bit ps_unit);
    longint unsigned p;
    longint unsigned t;
    p = longint'(period);
    t = cyc * p;
    return ps_unit ? t : t / 64'd1000;
  endfunction

  // One clock edge: advance the model with the inputs as seen at the edge,
  // then return at the falling edge where outputs are sampled.
  task automatic tick();
    longint unsigned pre_ps;
    @(posedge clk);
    pre_ps = cyc * longint'(PER_A);
    if (rst) begin
      cyc = 0; m_busy = 0; m_done = 0; m_target = 0; m_lap = 0; m_delta = 0;
    end else begin
      if (m_busy) begin
        m_done = (pre_ps >= m_target);
        if (m_done) m_busy = 0;
      end else begin
        m_done = 0;
        if (wait_start) begin
          m_target = pre_ps + wait_time;
          m_busy = 1;
        end
      end
`ifdef SIM_TIME_LAP_EN
      if (capture) begin
        m_delta = pre_ps - m_lap;
        m_lap = pre_ps;
      end
`endif
      cyc = cyc + 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; wait_start = 1; wait_time = 64'd5;
    tick(); tick();
    wait_start = 0;
    unit_ps = 1; #1;
    checks++; if (now_a !== 64'd0) begin failures++; $display("FAIL reset_ps_a: got %0d expected 0", now_a); end
    checks++; if (now_b !== 64'd0) begin failures++; $display("FAIL reset_ps_b: got %0d expected 0", now_b); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done_a); end
    unit_ps = 0; #1;
    checks++; if (now_a !== 64'd0) begin failures++; $display("FAIL reset_ns_a: got %0d expected 0", now_a); end
  endtask

  task automatic test_counts();
    rst = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      unit_ps = 1; #1;
      checks++; if (now_a !== exp_now(PER_A, 1)) begin failures++; $display("FAIL count_ps_a: got %0d expected %0d", now_a, exp_now(PER_A, 1)); end
      checks++; if (now_b !== exp_now(PER_B, 1)) begin failures++; $display("FAIL count_ps_b: got %0d expected %0d", now_b, exp_now(PER_B, 1)); end
      unit_ps = 0; #1;
      checks++; if (now_a !== exp_now(PER_A, 0)) begin failures++; $display("FAIL count_ns_a: got %0d expected %0d", now_a, exp_now(PER_A, 0)); end
      checks++; if (now_b !== exp_now(PER_B, 0)) begin failures++; $display("FAIL count_ns_b: got %0d expected %0d", now_b, exp_now(PER_B, 0)); end
    end
    unit_ps = 1; #1;
    checks++; if (now_a !== 64'd50000) begin failures++; $display("FAIL five_cycles_ps: got %0d expected 50000", now_a); end
    unit_ps = 0; #1;
    checks++; if (now_a !== 64'd50) begin failures++; $display("FAIL five_cycles_ns: got %0d expected 50", now_a); end
  endtask

  task automatic test_delay();
    int busy_cnt;
    int done_cnt;
    int done_at;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    rst = 1; tick(); rst = 0;
    wait_start = 1; wait_time = 64'd25000;
    tick();
    wait_start = 0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (busy_a !== m_busy) begin failures++; $display("FAIL delay_busy[%0d]: got %b expected %b", i, busy_a, m_busy); end
      checks++; if (done_a !== m_done) begin failures++; $display("FAIL delay_done[%0d]: got %b expected %b", i, done_a, m_done); end
      if (busy_a === 1'b1) busy_cnt++;
      if (done_a === 1'b1) begin done_cnt++; done_at = i; end
      tick();
    end
    checks++; if (busy_cnt != 3) begin failures++; $display("FAIL delay_busy_cycles: got %0d expected 3", busy_cnt); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL delay_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (done_at != 3) begin failures++; $display("FAIL delay_done_cycle: got %0d expected 3", done_at); end
  endtask

  task automatic test_back_to_back();
    wait_start = 1; wait_time = 64'd0;
    tick();
    wait_start = 0;
    checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin failures++; $display("FAIL zero_wait_busy: got busy=%b done=%b expected busy=1 done=0", busy_a, done_a); end
    tick();
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b1) begin failures++; $display("FAIL zero_wait_done: got busy=%b done=%b expected busy=0 done=1", busy_a, done_a); end
    wait_start = 1; wait_time = 64'd20000;
    tick();
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL back_to_back_start: got %b expected 1", busy_a); end
    wait_time = 64'd0;
    tick();
    wait_start = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (busy_a !== m_busy || done_a !== m_done) begin failures++; $display("FAIL ignore_while_busy[%0d]: got busy=%b done=%b expected busy=%b done=%b", i, busy_a, done_a, m_busy, m_done); end
      tick();
    end
  endtask

  task automatic test_reset_mid_delay();
    wait_start = 1; wait_time = 64'd50000;
    tick();
    wait_start = 0;
    tick();
    rst = 1; tick(); rst = 0;
    unit_ps = 1; #1;
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy_a); end
    checks++; if (now_a !== 64'd0) begin failures++; $display("FAIL midreset_now: got %0d expected 0", now_a); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL midreset_no_done[%0d]: got %b expected 0", i, done_a); end
      tick();
    end
  endtask

`ifdef SIM_TIME_LAP_EN
  task automatic test_lap();
    rst = 1; tick(); rst = 0;
    tick(); tick(); tick();
    capture = 1; tick(); capture = 0;
    checks++; if (lap_a !== 64'd30000) begin failures++; $display("FAIL lap_first: got %0d expected 30000", lap_a); end
    checks++; if (delta_a !== 64'd30000) begin failures++; $display("FAIL delta_first: got %0d expected 30000", delta_a); end
    tick(); tick(); tick();
    capture = 1; tick(); capture = 0;
    checks++; if (lap_a !== 64'd70000) begin failures++; $display("FAIL lap_second: got %0d expected 70000", lap_a); end
    checks++; if (delta_a !== 64'd40000) begin failures++; $display("FAIL delta_second: got %0d expected 40000", delta_a); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      wait_start = ($urandom_range(0, 2) == 0);
      wait_time = 64'($urandom_range(0, 60000));
      unit_ps = 1'($urandom_range(0, 1));
`ifdef SIM_TIME_LAP_EN
      capture = ($urandom_range(0, 3) == 0);
`endif
      tick();
      checks++; if (now_a !== exp_now(PER_A, unit_ps)) begin failures++; $display("FAIL rand_now_a[%0d]: got %0d expected %0d", i, now_a, exp_now(PER_A, unit_ps)); end
      checks++; if (now_b !== exp_now(PER_B, unit_ps)) begin failures++; $display("FAIL rand_now_b[%0d]: got %0d expected %0d", i, now_b, exp_now(PER_B, unit_ps)); end
      checks++; if (busy_a !== m_busy) begin failures++; $display("FAIL rand_busy[%0d]: got %b expected %b", i, busy_a, m_busy); end
      checks++; if (done_a !== m_done) begin failures++; $display("FAIL rand_done[%0d]: got %b expected %b", i, done_a, m_done); end
      checks++; if (busy_b !== 1'b0 || done_b !== 1'b0) begin failures++; $display("FAIL rand_idle_b[%0d]: got busy=%b done=%b expected 0 0", i, busy_b, done_b); end
`ifdef SIM_TIME_LAP_EN
      checks++; if (lap_a !== m_lap || delta_a !== m_delta) begin failures++; $display("FAIL rand_lap[%0d]: got lap=%0d delta=%0d expected lap=%0d delta=%0d", i, lap_a, delta_a, m_lap, m_delta); end
`endif
    end
    rst = 0; wait_start = 0;
`ifdef SIM_TIME_LAP_EN
    capture = 0;
`endif
  endtask

  initial begin
    test_reset();
    test_counts();
    test_delay();
    test_back_to_back();
    test_reset_mid_delay();
`ifdef SIM_TIME_LAP_EN
    test_lap();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
